// File: rtl/lieat_ifu_ibuf.sv
// Instruction buffer between fetch and decode: a small FIFO of {pc, inst, prdt_taken}
// with a valid/ready interface on both sides and a single-cycle flush.
module lieat_ifu_ibuf #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             if_i_valid,
    output logic             if_i_ready,
    input  logic [XLEN-1:0]  if_i_pc,
    input  logic [XLEN-1:0]  if_i_inst,
    input  logic             if_i_prdt_taken,
    output logic             id_o_valid,
    input  logic             id_o_ready,
    output logic [XLEN-1:0]  id_o_pc,
    output logic [XLEN-1:0]  id_o_inst,
    output logic             id_o_prdt_taken,
    input  logic             flush_req,
    output logic             ibuf_empty,
    output logic [PTR_W:0]   ibuf_count
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
        logic            prdt_taken;
    } ibuf_entry_t;

    ibuf_entry_t           mem [DEPTH];
    logic        [PTR_W:0] wptr;
    logic        [PTR_W:0] rptr;
    logic                  empty;
    logic                  full;
    logic                  push;
    logic                  pop;
    ibuf_entry_t           head;

    // Extra wrap bit distinguishes full from empty when the index bits match.
    assign empty = (wptr == rptr);
    assign full  = (wptr[PTR_W-1:0] == rptr[PTR_W-1:0]) && (wptr[PTR_W] != rptr[PTR_W]);

    // Ready ignores id_o_ready so there is no combinational path from decode to fetch.
    assign if_i_ready = ~full & ~flush_req;
    assign id_o_valid = ~empty & ~flush_req;

    assign push = if_i_valid & if_i_ready;
    assign pop  = id_o_valid & id_o_ready;

    assign head            = mem[rptr[PTR_W-1:0]];
    assign id_o_pc         = head.pc;
    assign id_o_inst       = head.inst;
    assign id_o_prdt_taken = head.prdt_taken;

    assign ibuf_empty = empty;
    assign ibuf_count = wptr - rptr;

    // Pointer and storage update; flush discards everything by catching rptr up to wptr.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (flush_req) begin
            rptr <= wptr;
        end else begin
            if (push) begin
                mem[wptr[PTR_W-1:0]] <= '{pc: if_i_pc, inst: if_i_inst, prdt_taken: if_i_prdt_taken};
                wptr                 <= wptr + (PTR_W+1)'(1);
            end
            if (pop) begin
                rptr <= rptr + (PTR_W+1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_lieat_ifu_ibuf.sv
// Directed and random stimulus for lieat_ifu_ibuf, checked against a queue-based FIFO model.
module tb_lieat_ifu_ibuf;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic            clk;
    logic            rstn;
    logic            if_i_valid;
    logic            if_i_ready;
    logic [XLEN-1:0] if_i_pc;
    logic [XLEN-1:0] if_i_inst;
    logic            if_i_prdt_taken;
    logic            id_o_valid;
    logic            id_o_ready;
    logic [XLEN-1:0] id_o_pc;
    logic [XLEN-1:0] id_o_inst;
    logic            id_o_prdt_taken;
    logic            flush_req;
    logic            ibuf_empty;
    logic [PTR_W:0]  ibuf_count;

    lieat_ifu_ibuf #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk             (clk),
        .rstn            (rstn),
        .if_i_valid      (if_i_valid),
        .if_i_ready      (if_i_ready),
        .if_i_pc         (if_i_pc),
        .if_i_inst       (if_i_inst),
        .if_i_prdt_taken (if_i_prdt_taken),
        .id_o_valid      (id_o_valid),
        .id_o_ready      (id_o_ready),
        .id_o_pc         (id_o_pc),
        .id_o_inst       (id_o_inst),
        .id_o_prdt_taken (id_o_prdt_taken),
        .flush_req       (flush_req),
        .ibuf_empty      (ibuf_empty),
        .ibuf_count      (ibuf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
        logic            t;
    } ent_t;

    ent_t q[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    logic last_push = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] inst,
                         input logic t, input logic rdy, input logic fl);
        if_i_valid      = v;
        if_i_pc         = pc;
        if_i_inst       = inst;
        if_i_prdt_taken = t;
        id_o_ready      = rdy;
        flush_req       = fl;
    endtask

    // Compare every visible output against what a FIFO of q.size() entries must show.
    task automatic check_outs();
        logic exp_valid;
        logic exp_ready;
        exp_valid = (q.size() > 0) && !flush_req;
        exp_ready = (q.size() < DEPTH) && !flush_req;
        chk("if_i_ready", 64'(if_i_ready), 64'(exp_ready));
        chk("id_o_valid", 64'(id_o_valid), 64'(exp_valid));
        chk("ibuf_empty", 64'(ibuf_empty), 64'(q.size() == 0));
        chk("ibuf_count", 64'(ibuf_count), 64'(q.size()));
        if (exp_valid) begin
            chk("id_o_pc", 64'(id_o_pc), 64'(q[0].pc));
            chk("id_o_inst", 64'(id_o_inst), 64'(q[0].inst));
            chk("id_o_prdt_taken", 64'(id_o_prdt_taken), 64'(q[0].t));
        end
    endtask

    // One clock: check outputs mid-cycle, decide handshakes from the model, advance at the edge.
    task automatic cycle();
        logic push;
        logic pop;
        #1;
        check_outs();
        push = if_i_valid && (q.size() < DEPTH) && !flush_req;
        pop  = (q.size() > 0) && id_o_ready && !flush_req;
        last_push = push;
        @(posedge clk);
        if (flush_req) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back('{pc: if_i_pc, inst: if_i_inst, t: if_i_prdt_taken});
        end
        @(negedge clk);
    endtask

    initial begin
        rstn = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_valid", 64'(id_o_valid), 64'(0));
        chk("rst_pc", 64'(id_o_pc), 64'(0));
        chk("rst_inst", 64'(id_o_inst), 64'(0));
        chk("rst_taken", 64'(id_o_prdt_taken), 64'(0));
        chk("rst_ready", 64'(if_i_ready), 64'(1));
        chk("rst_empty", 64'(ibuf_empty), 64'(1));
        chk("rst_count", 64'(ibuf_count), 64'(0));
        @(negedge clk);
        rstn = 1'b1;

        // Three pushes held at the head, then drained in order.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h8000_0000 + 32'(i * 4), 32'h0000_0013 + 32'(i), 1'b0, 1'b0, 1'b0);
            cycle();
        end
        drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        #1;
        chk("t1_count3", 64'(ibuf_count), 64'(3));
        chk("t1_head_pc", 64'(id_o_pc), 64'h8000_0000);
        for (int i = 0; i < 4; i++) cycle();
        #1;
        chk("t1_empty", 64'(ibuf_empty), 64'(1));

        // Fill to DEPTH; a fifth offer waits until one pop frees a slot.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h8000_0100 + 32'(i * 4), $urandom, 1'b0, 1'b0, 1'b0);
            cycle();
        end
        drive(1'b1, 32'h8000_0110, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
        #1;
        chk("t2_full_ready", 64'(if_i_ready), 64'(0));
        chk("t2_full_count", 64'(ibuf_count), 64'(4));
        cycle();
        drive(1'b1, 32'h8000_0110, 32'h1234_5678, 1'b1, 1'b1, 1'b0);
        cycle();
        drive(1'b1, 32'h8000_0110, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
        #1;
        chk("t2_ready_after_pop", 64'(if_i_ready), 64'(1));
        cycle();
        drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cycle();

        // Streaming: one in, one out per cycle; 20 pushes wrap the pointers twice.
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 32'h8000_0200 + 32'(i * 4), $urandom, 1'(i % 2), 1'b1, 1'b0);
            cycle();
        end
        drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        cycle();
        cycle();

        // Flush with a concurrent offer; the offer is refused and the buffer empties.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h8000_0300 + 32'(i * 4), $urandom, 1'b0, 1'b0, 1'b0);
            cycle();
        end
        drive(1'b1, 32'h8000_0400, 32'h0000_0013, 1'b0, 1'b1, 1'b1);
        #1;
        chk("t4_flush_ready", 64'(if_i_ready), 64'(0));
        chk("t4_flush_valid", 64'(id_o_valid), 64'(0));
        cycle();
        drive(1'b1, 32'h8000_1000, 32'h0000_0093, 1'b0, 1'b0, 1'b0);
        #1;
        chk("t4_count0", 64'(ibuf_count), 64'(0));
        cycle();
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("t4_new_head", 64'(id_o_pc), 64'h8000_1000);
        cycle();
        drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        cycle();

        // Predict-taken entry held at the head for five stalled cycles.
        drive(1'b1, 32'h8000_2000, 32'h0000_8067, 1'b1, 1'b0, 1'b0);
        cycle();
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t5_taken", 64'(id_o_prdt_taken), 64'(1));
            chk("t5_inst", 64'(id_o_inst), 64'h0000_8067);
            cycle();
        end
        drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        cycle();

        // Random traffic; an unaccepted offer stays on the bus unchanged.
        if_i_valid = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!(if_i_valid && !last_push)) begin
                if_i_valid      = 1'($urandom % 3 != 0);
                if_i_pc         = $urandom;
                if_i_inst       = $urandom;
                if_i_prdt_taken = 1'($urandom);
            end
            id_o_ready = 1'($urandom % 3 != 0);
            flush_req  = 1'($urandom % 25 == 0);
            cycle();
        end

        // Asynchronous reset with two entries queued.
        drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h8000_3000 + 32'(i * 4), 32'hdead_0000 + 32'(i), 1'b1, 1'b0, 1'b0);
            cycle();
        end
        drive(1'b1, 32'h8000_3008, 32'hdead_0002, 1'b1, 1'b1, 1'b0);
        #1;
        chk("t6_pre_count", 64'(ibuf_count), 64'(2));
        #1;
        rstn = 1'b0;
        #1;
        chk("t6_rst_valid", 64'(id_o_valid), 64'(0));
        chk("t6_rst_pc", 64'(id_o_pc), 64'(0));
        chk("t6_rst_taken", 64'(id_o_prdt_taken), 64'(0));
        chk("t6_rst_count", 64'(ibuf_count), 64'(0));
        chk("t6_rst_ready", 64'(if_i_ready), 64'(1));
        q.delete();
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("t6_rel_ready", 64'(if_i_ready), 64'(1));
        chk("t6_rel_valid", 64'(id_o_valid), 64'(0));
        chk("t6_rel_inst", 64'(id_o_inst), 64'(0));
        cycle();
        drive(1'b1, 32'h8000_4000, 32'h0000_0013, 1'b0, 1'b0, 1'b0);
        cycle();
        drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        cycle();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/lieat_ifu_ibuf.md
# lieat_ifu_ibuf

Instruction buffer between the fetch unit and `lieat_idu`. It is the transmitting end of the IDU's `id_i_*` valid/ready interface. It queues fetched {pc, inst, prdt_taken} triples in a small FIFO and presents the oldest one to decode. This decouples fetch bursts from decode/dispatch stalls. A pipeline flush drops all queued entries in one cycle.

## Interface

Parameters:
- `DEPTH`, default 4: number of entries. Must be a power of two and at least 2.
- `PTR_W`, default `$clog2(DEPTH)`: index width. Pointers carry one extra wrap bit.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `if_i_valid`  in  1  fetch offers an instruction.
- `if_i_ready`  out  1  buffer can accept one entry this cycle.
- `if_i_pc`  in  `XLEN`  PC of the offered instruction.
- `if_i_inst`  in  `XLEN`  instruction word.
- `if_i_prdt_taken`  in  1  branch-predictor taken flag.
- `id_o_valid`  out  1  head entry is presented to IDU (drives `id_i_valid`).
- `id_o_ready`  in  1  IDU accepts the head (from `id_i_ready`).
- `id_o_pc`  out  `XLEN`  head PC.
- `id_o_inst`  out  `XLEN`  head instruction.
- `id_o_prdt_taken`  out  1  head predict flag.
- `flush_req`  in  1  drop all entries.
- `ibuf_empty`  out  1  count == 0.
- `ibuf_count`  out  `PTR_W+1`  number of occupied entries, 0..DEPTH.

## Operation

- Storage: `DEPTH` entries of {pc, inst, prdt_taken}. Write pointer `wptr` and read pointer `rptr`, each `PTR_W+1` bits, wrap naturally modulo 2·DEPTH.
- Empty: `wptr == rptr`. Full: index bits are equal and wrap bits differ.
- `push = if_i_valid & if_i_ready`. The entry is written at `wptr[PTR_W-1:0]`, then `wptr` increments.
- `pop = id_o_valid & id_o_ready`. `rptr` increments.
- `if_i_ready = ~full & ~flush_req`. It does not depend on `id_o_ready`, so there is no combinational path from IDU back to fetch. A full buffer refuses a push even when a pop happens in the same cycle.
- `id_o_valid = ~empty & ~flush_req`.
- `id_o_*` data is read combinationally from entry `rptr[PTR_W-1:0]` and is held stable while `id_o_valid & ~id_o_ready`.
- Simultaneous push and pop (not full, not empty): both pointers advance and the count is unchanged.
- Push into an empty buffer: the entry is not bypassed to the output; it appears on the next cycle.
- Flush: on an edge with `flush_req=1`, `rptr <= wptr`. The count becomes 0. Entry contents are not cleared. Flush takes priority over any push or pop in the same cycle; neither can occur because both handshakes are gated off.
- `ibuf_count = wptr - rptr`, modulo 2·DEPTH, `PTR_W+1` bits. It is registered-derived, not combinational from inputs.
- A valid that is offered and not yet accepted stays on the bus. The buffer imposes no ordering requirement beyond FIFO order.

## Timing

- Reset (asynchronous assert, synchronous release at the next edge) sets:
  - `wptr=rptr=0`, all entries 0.
  - `id_o_valid=0`, `id_o_pc=0`, `id_o_inst=0`, `id_o_prdt_taken=0`.
  - `if_i_ready=1` (while `flush_req=0`), `ibuf_empty=1`, `ibuf_count=0`.
- Latency: a push at edge N gives `id_o_valid=1` with that data in cycle N+1, if it is at the head.
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.
- Full boundary: with count == DEPTH, `if_i_ready=0`. It rises in the cycle after the first pop.
- Empty boundary: the cycle after the last pop, `id_o_valid=0` and `ibuf_empty=1`.
- Flush at edge N: `if_i_ready` and `id_o_valid` are 0 throughout cycle N. In cycle N+1, `ibuf_empty=1` and `if_i_ready=1`.
- Pointer wrap: after 2·DEPTH pushes the pointers roll over with no bubble or data error.
- Reset asserted mid-transfer: state clears immediately and no partial entry is retained.

## Test plan

- Reset, then push pc=0x80000000/0x80000004/0x80000008 with `id_o_ready=0` → `ibuf_count=3`, head pc=0x80000000. Raise `id_o_ready` → pops in order over 3 cycles, then `ibuf_empty=1`.
- DEPTH=4: push 4 entries with `id_o_ready=0` → `if_i_ready=0`, count=4. A fifth valid is held off. One pop → `if_i_ready=1` the next cycle, and the fifth entry lands last.
- Streaming with `if_i_valid=1` and `id_o_ready=1` for 20 cycles, pcs incrementing by 4 → one output per cycle after a 1-cycle latency, in exact order. The pointers wrap at least twice.
- Fill 3 entries, assert `flush_req` for one cycle together with `if_i_valid=1` → that cycle `if_i_ready=0` and `id_o_valid=0`. Next cycle count=0. A new push pc=0x80001000 is the head one cycle later.
- Push with `if_i_prdt_taken=1`, inst=0x00008067, and hold `id_o_ready=0` for 5 cycles → outputs stay stable and `id_o_prdt_taken=1` throughout.
- Assert `rstn=0` asynchronously mid-stream with count=2 → outputs go to reset values immediately. After release, `if_i_ready=1` and `id_o_valid=0`.
